// File: rtl/squeeze_rd_pkg.sv
// Shared types and defaults for the squeeze-kernel RAM read-window sequencer.
package squeeze_rd_pkg;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_SEG_W  = 6;
    localparam int DEF_KER_W  = 6;
    localparam int DEF_DIM_W  = 7;
    localparam int DEF_REP_W  = 16;

    localparam logic MODE_FIRE = 1'b0;
    localparam logic MODE_CONV = 1'b1;

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;
endpackage

// File: rtl/sq_wrap_counter.sv
// Loop counter that steps 0..limit and wraps; wrap flags the last value.
module sq_wrap_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] value,
    output logic         wrap
);
    assign wrap = (value == limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (clear)
            value <= '0;
        else if (inc)
            value <= wrap ? '0 : value + W'(1);
    end
endmodule

// File: rtl/squeeze_rd_window_seq.sv
// Read-window sequencer: walks column/kernel/row loops and hands one
// registered address window per column to the RAM read controller.
module squeeze_rd_window_seq
    import squeeze_rd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SEG_W  = DEF_SEG_W,
    parameter int KER_W  = DEF_KER_W,
    parameter int DIM_W  = DEF_DIM_W,
    parameter int REP_W  = DEF_REP_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [SEG_W-1:0]  seg_len_i,
    input  logic [KER_W-1:0]  num_ker_i,
    input  logic [DIM_W-1:0]  dim_i,
    input  logic [REP_W-1:0]  tot_rep_i,
    output logic              win_valid_o,
    input  logic              win_ready_i,
    output logic [ADDR_W-1:0] win_start_o,
    output logic [ADDR_W-1:0] win_end_o,
    output logic              ker_done_o,
    output logic              row_done_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              cfg_err_o
);
    localparam int CW = ADDR_W + SEG_W + KER_W + 1;
    localparam int WW = ADDR_W + 1;

    state_t state, state_nxt;

    logic              mode_r;
    logic [ADDR_W-1:0] base_r;
    logic [SEG_W-1:0]  seg_r;
    logic [KER_W-1:0]  nker_r;
    logic [DIM_W-1:0]  dim_r;
    logic [REP_W-1:0]  rep_r;

    // Last address touched by the final kernel, wide enough to never overflow.
    logic [CW-1:0] last_addr;
    logic          cfg_ok;
    assign last_addr = CW'(base_addr_i) + CW'(num_ker_i) * CW'(seg_len_i)
                     + CW'(seg_len_i) - CW'(1);
    assign cfg_ok = (seg_len_i != '0) && (last_addr <= CW'((1 << ADDR_W) - 1));

    logic acc, col_w, ker_w, row_w, rep_w, fin, fire;
    logic [DIM_W-1:0] col_v, row_v;
    logic [KER_W-1:0] ker_v, ker_nxt, win_ker;
    logic [REP_W-1:0] rep_v;

    assign fire = (mode_r == MODE_FIRE);
    assign acc  = (state == ISSUE) && win_ready_i && !start_i;
    assign fin  = acc && col_w && (fire ? (ker_w && row_w) : rep_w);

    sq_wrap_counter #(.W(DIM_W)) u_col (
        .clk(clk_i), .rst(rst_i), .clear(start_i), .inc(acc),
        .limit(dim_r), .value(col_v), .wrap(col_w));

    sq_wrap_counter #(.W(KER_W)) u_ker (
        .clk(clk_i), .rst(rst_i), .clear(start_i), .inc(acc && col_w),
        .limit(nker_r), .value(ker_v), .wrap(ker_w));

    sq_wrap_counter #(.W(DIM_W)) u_row (
        .clk(clk_i), .rst(rst_i), .clear(start_i), .inc(acc && col_w && ker_w && fire),
        .limit(dim_r), .value(row_v), .wrap(row_w));

    sq_wrap_counter #(.W(REP_W)) u_rep (
        .clk(clk_i), .rst(rst_i), .clear(start_i), .inc(acc && col_w && !fire),
        .limit(rep_r), .value(rep_v), .wrap(rep_w));

    // Window for the kernel that will be current after this cycle's update.
    logic [WW-1:0] nxt_start, nxt_end;
    assign ker_nxt   = ker_w ? '0 : ker_v + KER_W'(1);
    assign win_ker   = (state == ISSUE) ? ker_nxt : '0;
    assign nxt_start = WW'(base_r) + WW'(CW'(win_ker) * CW'(seg_r));
    assign nxt_end   = nxt_start + WW'(seg_r) - WW'(1);

    logic unused_bits;
    assign unused_bits = ^{col_v, row_v, rep_v, nxt_start[ADDR_W], nxt_end[ADDR_W]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            LOAD:    state_nxt = ISSUE;
            ISSUE:   if (fin) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A start from any state restarts (or rejects) the sequence.
        if (start_i)
            state_nxt = cfg_ok ? LOAD : IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_r <= MODE_FIRE;
            base_r <= '0;
            seg_r  <= '0;
            nker_r <= '0;
            dim_r  <= '0;
            rep_r  <= '0;
        end else if (start_i) begin
            mode_r <= mode_i;
            base_r <= base_addr_i;
            seg_r  <= seg_len_i;
            nker_r <= num_ker_i;
            dim_r  <= dim_i;
            rep_r  <= tot_rep_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_start_o <= '0;
            win_end_o   <= '0;
        end else if (!start_i && (state == LOAD || (acc && col_w))) begin
            win_start_o <= nxt_start[ADDR_W-1:0];
            win_end_o   <= nxt_end[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ker_done_o <= 1'b0;
            row_done_o <= 1'b0;
            cfg_err_o  <= 1'b0;
        end else begin
            ker_done_o <= acc && col_w;
            row_done_o <= acc && col_w && ker_w && fire;
            cfg_err_o  <= start_i && !cfg_ok;
        end
    end

    assign win_valid_o = (state == ISSUE);
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
endmodule
